fetch_stage: RTL

- Instruction-fetch front end for the pipelined processor. Sits directly upstream of decode.
- Owns the IAR/PC and issues one-outstanding requests to a variable-latency instruction memory.
- Buffers returned words through a one-entry hold buffer, and presents an IF/ID register (instr, pc, pc+4, valid) to decode.
- Accepts stall from the hazard unit and redirect (branch/jump target) from execute.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// One request strobe with its word address; the memory answers some cycles
// later with a response strobe and the instruction word. Requests are always
// accepted, so there is no ready signal.
interface fetch_stage_if;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;

    // Fetch side: issues requests and consumes responses
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side: accepts requests and produces responses
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. Owns the PC and keeps at most one request
// outstanding to a variable-latency instruction memory. Words that arrive
// while decode is stalled park in a one-entry hold buffer. The IF/ID register
// (instr, pc, pc+4, valid) feeds decode. A redirect from execute flushes
// IF/ID and the hold buffer. A response still in flight is marked for
// discard (KILL) and fetching restarts at the word-aligned target.
//
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched / perf_bubbles
// counter outputs; without it the ports and counters do not exist.
module fetch_stage #(
    parameter logic [0:31] RESET_PC  = 32'h0000_0000,
    parameter logic [0:31] NOP_INSTR = 32'h5400_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    fetch_stage_if.master imem,
    output logic        id_valid,
    output logic [0:31] id_instr,
    output logic [0:31] id_pc,
    output logic [0:31] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [0:31] perf_fetched,
    output logic [0:31] perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [0:31] pc;
    logic [0:31] req_pc;

    logic        hold_valid;
    logic [0:31] hold_instr;
    logic [0:31] hold_pc;

    logic [0:31] id_instr_q;

    logic [0:31] redirect_word;
    logic        issue;
    logic        resp_live;
    logic        resp_to_id;
    logic        resp_to_hold;
    logic        hold_to_id;

    // The target is forced onto a word boundary; the low two bits are dropped
    assign redirect_word = redirect_pc & 32'hFFFF_FFFC;

    // A new request goes out only when nothing is outstanding, the hold buffer
    // has room for the answer, and no redirect is changing the PC this cycle
    assign issue = (state == IDLE) && !hold_valid && !redirect && !reset;

    // A response is kept only when it belongs to a live request and is not
    // being flushed by a same-cycle redirect
    assign resp_live    = (state == WAIT) && imem.imem_rvalid && !redirect;
    assign resp_to_id   = resp_live && (!id_valid || !stall);
    assign resp_to_hold = resp_live && id_valid && stall;

    // A parked word moves forward as soon as decode is free to take it
    assign hold_to_id = hold_valid && !stall;

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc;

    // Invalid IF/ID slots always present a NOP to decode
    assign id_instr = id_valid ? id_instr_q : NOP_INSTR;

    // Request-tracking state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next request state: issue opens WAIT, a redirect turns WAIT into KILL,
    // and any response closes the outstanding request
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_next = IDLE;
                end else if (redirect) begin
                    state_next = KILL;
                end
            end
            KILL: begin
                if (imem.imem_rvalid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC advances on each issued request and jumps on redirect; req_pc
    // remembers which address the outstanding request is for
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_pc <= 32'h0000_0000;
        end else if (redirect) begin
            pc <= redirect_word;
        end else if (issue) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
        end
    end

    // Hold buffer catches a word that arrives while IF/ID is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_instr <= 32'h0000_0000;
            hold_pc    <= 32'h0000_0000;
        end else if (redirect) begin
            hold_valid <= 1'b0;
        end else if (hold_to_id) begin
            hold_valid <= 1'b0;
        end else if (resp_to_hold) begin
            hold_valid <= 1'b1;
            hold_instr <= imem.imem_rdata;
            hold_pc    <= req_pc;
        end
    end

    // IF/ID register: redirect flush, then hold drain, then fresh response,
    // then consumption by decode; a stall with nothing to do holds contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_instr_q  <= NOP_INSTR;
            id_pc       <= 32'h0000_0000;
            id_pc_plus4 <= 32'h0000_0000;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (hold_to_id) begin
            id_valid    <= 1'b1;
            id_instr_q  <= hold_instr;
            id_pc       <= hold_pc;
            id_pc_plus4 <= hold_pc + 32'd4;
        end else if (resp_to_id) begin
            id_valid    <= 1'b1;
            id_instr_q  <= imem.imem_rdata;
            id_pc       <= req_pc;
            id_pc_plus4 <= req_pc + 32'd4;
        end else if (id_valid && !stall) begin
            id_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts fresh words captured and cycles decode sees no instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'h0000_0000;
            perf_bubbles <= 32'h0000_0000;
        end else begin
            if (resp_to_id || resp_to_hold) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (!id_valid) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
